// File: rtl/round_key_reader_pkg.sv
// Shared AES-128 key-schedule sizes, reader state encoding and round-sequencing helpers.
package round_key_reader_pkg;

    localparam int NK    = 4;
    localparam int NR    = 10;
    localparam int KEY_S = 32 * NK;

    typedef logic [3:0] round_t;

    localparam round_t NR_ROUND = round_t'(NR);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rk_state_t;

    function automatic round_t first_round(input logic decrypt);
        return decrypt ? NR_ROUND : round_t'(0);
    endfunction

    function automatic round_t last_round(input logic decrypt);
        return decrypt ? round_t'(0) : NR_ROUND;
    endfunction

    function automatic round_t next_round(input round_t r, input logic decrypt);
        return decrypt ? r - round_t'(1) : r + round_t'(1);
    endfunction

endpackage

// File: rtl/round_key_ram.sv
// Round-key storage: one write port, one registered read port.
// Latency: read data one cycle after re; backpressure: none, the read register holds while re=0.
// Out-of-range write addresses are dropped.
module round_key_ram
    import round_key_reader_pkg::*;
#(
    parameter int WIDTH = KEY_S,
    parameter int DEPTH = NR + 1,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array itself is never reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST_ADDR)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/round_key_reader.sv
// Stores a key schedule and streams it out in round order, forward or reverse.
// Latency: first key one cycle after an accepted start, then one key per accepted transfer.
// Backpressure: rk_ready low holds the offered key; generator writes are never stalled.
module round_key_reader
    import round_key_reader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             w_e,
    input  logic [3:0]       round_key_addr,
    input  logic [KEY_S-1:0] round_key,
    input  logic             key_done,
    input  logic             start,
    input  logic             decrypt,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [KEY_S-1:0] rk_data,
    output logic [3:0]       rk_round,
    output logic             rk_last,
    output logic             keys_valid,
    output logic             busy,
    output logic             aborted
);

    rk_state_t state;
    logic      dir;
    logic      wr0;
    logic      load_first;
    logic      advance;
    logic      rd_en;
    round_t    rd_addr;
    round_t    nxt;

    assign wr0 = w_e && (round_key_addr == 4'd0);
    assign nxt = next_round(rk_round, dir);

    // Prefetch the next key into the read register exactly when the FSM moves on,
    // so rk_data is the RAM output and stays put while stalled.
    assign load_first = (state == ST_IDLE) && start && keys_valid;
    assign advance    = (state == ST_STREAM) && !wr0 && rk_valid && rk_ready && !rk_last;
    assign rd_en      = load_first || advance;
    assign rd_addr    = load_first ? first_round(decrypt) : nxt;

    assign busy = (state == ST_STREAM);

    round_key_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_e),
        .waddr (round_key_addr),
        .wdata (round_key),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rk_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rk_valid   <= 1'b0;
            rk_last    <= 1'b0;
            rk_round   <= '0;
            keys_valid <= 1'b0;
            aborted    <= 1'b0;
            dir        <= 1'b0;
        end else begin
            aborted <= 1'b0;

            if (wr0) begin
                keys_valid <= 1'b0;
            end else if (key_done) begin
                keys_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start && keys_valid) begin
                        state    <= ST_STREAM;
                        rk_valid <= 1'b1;
                        rk_round <= first_round(decrypt);
                        rk_last  <= 1'b0;
                        dir      <= decrypt;
                    end
                end
                ST_STREAM: begin
                    // A new schedule overwriting round 0 invalidates the stream in flight.
                    if (wr0) begin
                        state    <= ST_IDLE;
                        rk_valid <= 1'b0;
                        rk_last  <= 1'b0;
                        aborted  <= 1'b1;
                    end else if (rk_valid && rk_ready) begin
                        if (rk_last) begin
                            state    <= ST_IDLE;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                        end else begin
                            rk_round <= nxt;
                            rk_last  <= (nxt == last_round(dir));
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    rk_valid <= 1'b0;
                    rk_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_reader.sv
// Directed bench for round_key_reader with a scoreboard of expected round keys.
module tb_round_key_reader;
    import round_key_reader_pkg::*;

    typedef struct {
        logic [3:0]       round;
        logic [KEY_S-1:0] data;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             w_e;
    logic [3:0]       round_key_addr;
    logic [KEY_S-1:0] round_key;
    logic             key_done;
    logic             start;
    logic             decrypt;
    logic             rk_ready;
    logic             rk_valid;
    logic [KEY_S-1:0] rk_data;
    logic [3:0]       rk_round;
    logic             rk_last;
    logic             keys_valid;
    logic             busy;
    logic             aborted;

    logic [KEY_S-1:0] keys [0:10];
    exp_t             exp_q [$];
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    round_key_reader dut (
        .clk            (clk),
        .reset          (reset),
        .w_e            (w_e),
        .round_key_addr (round_key_addr),
        .round_key      (round_key),
        .key_done       (key_done),
        .start          (start),
        .decrypt        (decrypt),
        .rk_ready       (rk_ready),
        .rk_valid       (rk_valid),
        .rk_data        (rk_data),
        .rk_round       (rk_round),
        .rk_last        (rk_last),
        .keys_valid     (keys_valid),
        .busy           (busy),
        .aborted        (aborted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [KEY_S-1:0] obs, input logic [KEY_S-1:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_all();
        for (int r = 0; r <= NR; r++) begin
            w_e = 1'b1; round_key_addr = 4'(r); round_key = keys[r];
            step();
        end
        w_e = 1'b0;
    endtask

    task automatic load_keys();
        write_all();
        key_done = 1'b1;
        step();
        key_done = 1'b0;
        chk(keys_valid, 1, "load_keys_valid");
    endtask

    // Streams one schedule through the scoreboard; stall_pct sets the rk_ready low rate,
    // poke overwrites round 5 in storage while round 5 is being offered.
    task automatic stream(input logic dec, input int stall_pct, input bit poke);
        int   cyc     = 0;
        int   n_xfer  = 0;
        bit   stalled = 0;
        bit   poked   = 0;
        bit   rdy;
        exp_t e;
        logic [KEY_S-1:0] held_data;
        logic [3:0]       held_round;
        logic             held_last;

        for (int i = 0; i <= NR; i++) begin
            e.round = dec ? 4'(NR - i) : 4'(i);
            e.data  = keys[e.round];
            e.last  = (i == NR);
            exp_q.push_back(e);
        end

        start = 1'b1; decrypt = dec;
        step();
        start = 1'b0; decrypt = ~dec;
        chk(rk_valid, 1, "first_valid");
        chk(busy, 1, "first_busy");

        while (exp_q.size() != 0 && cyc < 300) begin
            start = 1'b0;
            w_e   = 1'b0;
            if (stalled) begin
                chk(rk_data, held_data, "stall_data");
                chk(rk_round, held_round, "stall_round");
                chk(rk_last, held_last, "stall_last");
            end
            rdy = ($urandom_range(0, 99) >= stall_pct);
            if (poke && !poked && rk_round == 4'd5) begin
                rdy = 1'b0; poked = 1'b1;
                w_e = 1'b1; round_key_addr = 4'd5; round_key = ~keys[5];
            end
            rk_ready = rdy;
            chk(rk_valid, 1, "valid_in_stream");
            if (rdy) begin
                e = exp_q.pop_front();
                chk(rk_round, e.round, "sb_round");
                chk(rk_data, e.data, "sb_data");
                chk(rk_last, e.last, "sb_last");
                n_xfer++;
                if (e.last) start = 1'b1;
                stalled = 1'b0;
            end else begin
                held_data = rk_data; held_round = rk_round; held_last = rk_last;
                stalled = 1'b1;
            end
            step();
            cyc++;
        end
        start = 1'b0; w_e = 1'b0; rk_ready = 1'b0;
        chk(exp_q.size(), 0, "sb_drain");
        chk(n_xfer, NR + 1, "xfer_count");
        chk(rk_valid, 0, "valid_after_last");
        chk(busy, 0, "busy_after_last");
        exp_q.delete();
        if (poke) begin
            w_e = 1'b1; round_key_addr = 4'd5; round_key = keys[5];
            step();
            w_e = 1'b0;
        end
    endtask

    initial begin
        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b1; w_e = 1'b0; round_key_addr = '0; round_key = '0;
        key_done = 1'b0; start = 1'b0; decrypt = 1'b0; rk_ready = 1'b0;
        step(); step();
        chk(rk_valid, 0, "rst_valid");
        chk(rk_last, 0, "rst_last");
        chk(rk_round, 0, "rst_round");
        chk(rk_data, 0, "rst_data");
        chk(keys_valid, 0, "rst_keys_valid");
        chk(busy, 0, "rst_busy");
        chk(aborted, 0, "rst_aborted");
        reset = 1'b0;
        step();

        // Start before key_done is ignored.
        write_all();
        start = 1'b1;
        step();
        start = 1'b0;
        chk(rk_valid, 0, "early_start_valid");
        chk(busy, 0, "early_start_busy");
        chk(keys_valid, 0, "early_keys_valid");

        // key_done colliding with a round-0 write: the write wins.
        w_e = 1'b1; round_key_addr = 4'd0; round_key = keys[0]; key_done = 1'b1;
        step();
        w_e = 1'b0; key_done = 1'b0;
        chk(keys_valid, 0, "done_vs_wr0");
        key_done = 1'b1;
        step();
        key_done = 1'b0;
        chk(keys_valid, 1, "done_sets_valid");
        w_e = 1'b1; round_key_addr = 4'd0;
        step();
        w_e = 1'b0;
        chk(keys_valid, 0, "wr0_clears_valid");

        load_keys();
        stream(1'b0, 0, 1'b0);
        stream(1'b1, 0, 1'b0);
        stream(1'b0, 40, 1'b1);
        stream(1'b1, 50, 1'b0);

        // Round-0 write on the 4th transfer aborts the stream.
        start = 1'b1; decrypt = 1'b0;
        step();
        start = 1'b0; rk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk(rk_round, 4'(i), "abort_pre_round");
            step();
        end
        chk(rk_round, 3, "abort_4th_round");
        w_e = 1'b1; round_key_addr = 4'd0; round_key = keys[0];
        step();
        w_e = 1'b0; rk_ready = 1'b0;
        chk(aborted, 1, "abort_pulse");
        chk(rk_valid, 0, "abort_valid");
        chk(busy, 0, "abort_busy");
        chk(keys_valid, 0, "abort_keys_valid");
        step();
        chk(aborted, 0, "abort_one_cycle");

        // Reset mid-stream.
        load_keys();
        start = 1'b1; decrypt = 1'b1;
        step();
        start = 1'b0; rk_ready = 1'b1;
        step(); step();
        chk(rk_round, 8, "pre_reset_round");
        reset = 1'b1;
        step();
        chk(rk_valid, 0, "mrst_valid");
        chk(rk_last, 0, "mrst_last");
        chk(rk_round, 0, "mrst_round");
        chk(rk_data, 0, "mrst_data");
        chk(keys_valid, 0, "mrst_keys_valid");
        chk(busy, 0, "mrst_busy");
        chk(aborted, 0, "mrst_aborted");
        reset = 1'b0; rk_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_key_reader.md
ROUND_KEY_READER -- requirements
Module: round_key_reader

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 w_e  in  1  write strobe from the key-schedule generator.
REQ-004 round_key_addr  in  4  write address, round index 0..`Nr.
REQ-005 round_key  in  `KEY_S  round key to store when w_e=1.
REQ-006 key_done  in  1  one-cycle pulse: the full schedule has been written (generator en_o).
REQ-007 start  in  1  one-cycle request to stream the schedule.
REQ-008 decrypt  in  1  direction, sampled with start: 0 = rounds 0..`Nr, 1 = rounds `Nr..0.
REQ-009 rk_ready  in  1  consumer accepts rk_data this cycle.
REQ-010 rk_valid  out  1  rk_data/rk_round/rk_last are valid.
REQ-011 rk_data  out  `KEY_S  round key being offered.
REQ-012 rk_round  out  4  round index of rk_data.
REQ-013 rk_last  out  1  high with the final key of a stream.
REQ-014 keys_valid  out  1  a complete schedule is stored.
REQ-015 busy  out  1  a stream is in progress.
REQ-016 aborted  out  1  one-cycle pulse: stream cancelled by a new schedule.

Function
REQ-017 Storage SHALL hold `Nr+1 entries of `KEY_S bits, written at round_key_addr when w_e=1; addresses > `Nr SHALL be ignored.
REQ-018 Writes SHALL be accepted in every state, with no back-pressure on the generator.
REQ-019 keys_valid SHALL rise the cycle after key_done and fall the cycle after any write to address 0.
REQ-020 If key_done and a write to address 0 coincide, keys_valid SHALL be 0 next cycle (the write wins).
REQ-021 FSM states: IDLE, STREAM.
REQ-022 IDLE -> STREAM on start=1 && keys_valid=1; start in any other case SHALL be ignored.
REQ-023 rk_valid SHALL assert the cycle after an accepted start, carrying round 0 (decrypt=0) or `Nr (decrypt=1).
REQ-024 A transfer SHALL occur when rk_valid && rk_ready; the next key SHALL be presented the following cycle, allowing one key per cycle under continuous rk_ready.
REQ-025 While rk_valid && !rk_ready, rk_data, rk_round and rk_last SHALL hold stable.
REQ-026 rk_last SHALL be high only with round `Nr (encrypt) or round 0 (decrypt).
REQ-027 A transfer with rk_last=1 SHALL return the FSM to IDLE and drop rk_valid next cycle; start in that same cycle SHALL be ignored.
REQ-028 busy SHALL equal (state == STREAM).
REQ-029 A write to address 0 in STREAM SHALL abort: next cycle rk_valid=0, state IDLE, aborted=1 for one cycle.
REQ-030 Writes to addresses other than 0 in STREAM SHALL update storage; data already registered on rk_data SHALL not change.
REQ-031 Total stream SHALL be exactly `Nr+1 transfers, with no gaps or duplicate rounds.

Reset
REQ-032 Reset SHALL force: state IDLE, rk_valid=0, rk_last=0, rk_round=0, rk_data=0, keys_valid=0, busy=0, aborted=0.
REQ-033 Storage contents SHALL be left unreset (not observable until keys_valid=1).
REQ-034 Reset mid-stream SHALL terminate the stream without asserting aborted.

Structure
REQ-035 `KEY_S, `Nr, `Nk and the FSM state encodings SHALL live in aes.vh.
REQ-036 Storage SHALL be a sub-module round_key_ram: one write port and one registered read port, mappable to distributed RAM.

Verification
REQ-037 Full generator run for FIPS-197 key 2b7e1516..., key_done, then start with decrypt=0 and rk_ready=1 -> 11 consecutive keys, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
REQ-038 Same schedule, decrypt=1 -> first key is round 10, last key is round 0 = 2b7e1516... with rk_last=1.
REQ-039 Random rk_ready stalls -> outputs stable during stalls and exactly 11 transfers in order.
REQ-040 start before key_done -> no rk_valid, busy=0.
REQ-041 Write to address 0 at the 4th transfer -> aborted pulses, rk_valid=0 next cycle, keys_valid=0.
REQ-042 Reset asserted mid-stream -> all outputs at reset values next cycle, aborted=0.
